// File: rtl/eq_seq_pkg.sv
// rtl/eq_seq_pkg.sv - shared types and helpers for the serial equality sequencer
package eq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic x1;
    logic y1;
    logic x2;
    logic y2;
  } pair_t;

  // Index width for np pairs; a single pair still needs one index bit.
  function automatic int idx_width(input int np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/eq_pair_mux.sv
// rtl/eq_pair_mux.sv - selects bit-pair idx of both operands for the slice
module eq_pair_mux
  import eq_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDXW  = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDXW-1:0]  idx,
  output pair_t            pair
);

  localparam int NP = WIDTH / 2;

  logic [NP-1:0][1:0] a_pairs;
  logic [NP-1:0][1:0] b_pairs;

  always_comb begin
    a_pairs = a;
    b_pairs = b;
    pair.x1 = a_pairs[idx][0];
    pair.y1 = b_pairs[idx][0];
    pair.x2 = a_pairs[idx][1];
    pair.y2 = b_pairs[idx][1];
  end

endmodule

// File: rtl/eq_slice_seq.sv
// rtl/eq_slice_seq.sv - walks two words LSB-first through an external 2-bit equality slice
module eq_slice_seq
  import eq_seq_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int EARLY_EXIT = 1,
  localparam int NP         = WIDTH / 2,
  localparam int IDXW       = idx_width(NP)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [WIDTH-1:0] word_a,
  input  logic [WIDTH-1:0] word_b,
  output logic            slice_x1,
  output logic            slice_y1,
  output logic            slice_x2,
  output logic            slice_y2,
  input  logic            slice_a,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [IDXW-1:0] mismatch_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NP - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            match;
  pair_t           pair;
  logic            stop;

  eq_pair_mux #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_pair_mux (
    .a    (a_q),
    .b    (b_q),
    .idx  (idx),
    .pair (pair)
  );

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    slice_x1    = 1'b0;
    slice_y1    = 1'b0;
    slice_x2    = 1'b0;
    slice_y2    = 1'b0;
    stop        = ((EARLY_EXIT != 0) && !slice_a) || (idx == LAST_IDX);
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        slice_x1 = pair.x1;
        slice_y1 = pair.y1;
        slice_x2 = pair.x2;
        slice_y2 = pair.y2;
        if (stop) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      match        <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q          <= word_a;
            b_q          <= word_b;
            idx          <= '0;
            match        <= 1'b1;
            equal        <= 1'b0;
            mismatch_idx <= '0;
          end
        end
        RUN: begin
          // Only the first mismatching pair is recorded.
          if (!slice_a && match) begin
            mismatch_idx <= idx;
            match        <= 1'b0;
          end
          if (stop) equal <= match & slice_a;
          else      idx   <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_slice_seq.sv
// tb/tb_eq_slice_seq.sv - scoreboard bench running early-exit and full-sweep sequencers side by side
module tb_eq_slice_seq;

  localparam int WIDTH = 16;
  localparam int NP    = WIDTH / 2;
  localparam int IDXW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start_valid;
  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;

  logic e_ready, e_x1, e_y1, e_x2, e_y2, e_sa, e_busy, e_done, e_equal;
  logic f_ready, f_x1, f_y1, f_x2, f_y2, f_sa, f_busy, f_done, f_equal;
  logic [IDXW-1:0] e_midx, f_midx;

  // Golden external slice for each instance.
  assign e_sa = (e_x1 == e_y1) & (e_x2 == e_y2);
  assign f_sa = (f_x1 == f_y1) & (f_x2 == f_y2);

  eq_slice_seq #(.WIDTH(WIDTH), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(e_ready),
    .word_a(word_a), .word_b(word_b),
    .slice_x1(e_x1), .slice_y1(e_y1), .slice_x2(e_x2), .slice_y2(e_y2),
    .slice_a(e_sa), .busy(e_busy), .done(e_done), .equal(e_equal), .mismatch_idx(e_midx)
  );

  eq_slice_seq #(.WIDTH(WIDTH), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(f_ready),
    .word_a(word_a), .word_b(word_b),
    .slice_x1(f_x1), .slice_y1(f_y1), .slice_x2(f_x2), .slice_y2(f_y2),
    .slice_a(f_sa), .busy(f_busy), .done(f_done), .equal(f_equal), .mismatch_idx(f_midx)
  );

  typedef struct {
    bit eq;
    int idx;
    int at;
  } exp_t;

  exp_t q_e[$];
  exp_t q_f[$];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: first differing 2-bit pair decides the verdict and the timing.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit early, input int acc);
    exp_t r;
    int first = -1;
    for (int k = 0; k < NP; k++)
      if (first < 0 && ((a >> (2 * k)) & 2'b11) != ((b >> (2 * k)) & 2'b11)) first = k;
    r.eq  = (first < 0);
    r.idx = (first < 0) ? 0 : first;
    r.at  = (early && first >= 0) ? acc + first + 1 : acc + NP;
    return r;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    while (!(e_ready && f_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    word_a      = a;
    word_b      = b;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    q_e.push_back(model(a, b, 1'b1, cyc));
    q_f.push_back(model(a, b, 1'b0, cyc));
    word_a = WIDTH'($urandom);
    word_b = WIDTH'($urandom);
  endtask

  always @(negedge clk) begin : mon_early
    exp_t x;
    if (rst_n && e_done) begin
      if (q_e.size() == 0) chk("early_unexpected_done", 1, 0);
      else begin
        x = q_e.pop_front();
        chk("early_equal", e_equal, x.eq);
        chk("early_midx", e_midx, x.idx);
        chk("early_latency", cyc, x.at);
        chk("early_slice_idle", {e_x1, e_y1, e_x2, e_y2}, 0);
        chk("early_ready_in_done", {e_ready, e_busy}, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_full
    exp_t x;
    if (rst_n && f_done) begin
      if (q_f.size() == 0) chk("full_unexpected_done", 1, 0);
      else begin
        x = q_f.pop_front();
        chk("full_equal", f_equal, x.eq);
        chk("full_midx", f_midx, x.idx);
        chk("full_latency", cyc, x.at);
        chk("full_slice_idle", {f_x1, f_y1, f_x2, f_y2}, 0);
        chk("full_ready_in_done", {f_ready, f_busy}, 0);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((q_e.size() != 0 || q_f.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    word_a      = '0;
    word_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_early", {e_ready, e_busy, e_done, e_equal, 1'b0, e_midx}, 32'h80);
    chk("reset_full", {f_ready, f_busy, f_done, f_equal, 1'b0, f_midx}, 32'h80);
    chk("reset_slice", {e_x1, e_y1, e_x2, e_y2, f_x1, f_y1, f_x2, f_y2}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'hA5A5, 16'hA5A5);
    issue(16'h0001, 16'h0000);
    issue(16'h8000, 16'h0000);
    issue(16'h0104, 16'h0000);
    drain();
    chk("hold_equal_after_done", {e_equal, f_equal}, 0);
    chk("hold_midx_after_done", {e_midx, f_midx}, {3'd1, 3'd1});

    // Reset in the middle of a run abandons it silently.
    issue(16'h1234, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", {e_busy, f_busy}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_e.delete();
    q_f.delete();
    chk("after_reset_ready", {e_ready, f_ready, e_busy, f_busy}, 4'b1100);
    repeat (NP + 3) @(posedge clk);
    #1;
    issue(16'h3C3C, 16'h3C3C);
    drain();

    // Start pulses during RUN must be ignored.
    issue(16'h5A5A, 16'h5A5A);
    @(posedge clk); #1;
    word_a      = 16'hFFFF;
    word_b      = 16'h0000;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    issue(16'h00F0, 16'h0070);
    drain();

    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        2:       b = a ^ (WIDTH'(3) << (2 * $urandom_range(0, NP - 1)));
        default: b = WIDTH'($urandom);
      endcase
      issue(a, b);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
